// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the helpers that map a byte offset onto a word lane.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    DONE
  } state_t;

  // A byte lane is 8 bits wide, so lane n starts at bit n << LANE_SHIFT.
  localparam int unsigned LANE_SHIFT = 3;

  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return 5'(off) << LANE_SHIFT;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_load);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: picks and extends a byte/half out of a RAM word for
// loads, and merges store data into the addressed lane for sub-word stores.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byteOff_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] loadData_o,
  output logic [31:0] storeData_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [4:0]  byteShift;
  logic [4:0]  halfShift;

  always_comb begin
    byteLane  = 8'h00;
    halfLane  = 16'h0000;
    byteShift = lane_shift(byteOff_i);
    halfShift = lane_shift({byteOff_i[1], 1'b0});

    case (byteOff_i)
      2'd0:    byteLane = word_i[7:0];
      2'd1:    byteLane = word_i[15:8];
      2'd2:    byteLane = word_i[23:16];
      default: byteLane = word_i[31:24];
    endcase

    halfLane = byteOff_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    loadData_o = word_i;
    case (funct3_i)
      F3_B:    loadData_o = {{24{byteLane[7]}}, byteLane};
      F3_BU:   loadData_o = {24'h000000, byteLane};
      F3_H:    loadData_o = {{16{halfLane[15]}}, halfLane};
      F3_HU:   loadData_o = {16'h0000, halfLane};
      default: loadData_o = word_i;
    endcase
  end

  // Sub-word stores keep every lane of the old word except the addressed one.
  always_comb begin
    storeData_o = wdata_i;
    case (funct3_i)
      F3_B:    storeData_o = (word_i & ~(32'h0000_00FF << byteShift))
                           | ({24'h000000, wdata_i[7:0]} << byteShift);
      F3_H:    storeData_o = (word_i & ~(32'h0000_FFFF << halfShift))
                           | ({16'h0000, wdata_i[15:0]} << halfShift);
      default: storeData_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_handler.sv
// Load/store unit sitting in front of the single-port word RAM. Turns one
// byte-addressed CPU access into word reads/writes, with RMW for sub-word stores.
module mem_handler
  import mem_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata
);

  state_t            state_q;
  logic [ADDR_W+1:0] latAddr_q;
  logic [2:0]        latFunct3_q;
  logic [31:0]       latWdata_q;
  logic              isStore_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ramWdata_q;
  logic              ramWe_q;
  logic              ramRe_q;
  logic              done_q;
  logic              err_q;

  logic              request_d;
  logic              reject_d;
  logic              accept_d;
  logic [31:0]       laneLoad;
  logic [31:0]       laneStore;

  // Request screening: anything ambiguous, misaligned, out of range or with a
  // width code that makes no sense for the direction is bounced with err.
  always_comb begin
    request_d = mem_read | mem_write;
    reject_d  = 1'b0;
    if (request_d) begin
      reject_d = (mem_read & mem_write)
               | ~funct3_legal(funct3, mem_read)
               | misaligned(funct3, addr[1:0])
               | (addr[31:ADDR_W+2] != '0);
    end
    accept_d = request_d & ~reject_d;
  end

  mem_lane_unit u_lane (
    .word_i      (ram_rdata),
    .byteOff_i   (latAddr_q[1:0]),
    .funct3_i    (latFunct3_q),
    .wdata_i     (latWdata_q),
    .loadData_o  (laneLoad),
    .storeData_o (laneStore)
  );

  // Strobes and pulses default low every cycle; each state raises only what it owns.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      latAddr_q   <= '0;
      latFunct3_q <= 3'b000;
      latWdata_q  <= 32'h0;
      isStore_q   <= 1'b0;
      rdata_q     <= 32'h0;
      ramWdata_q  <= 32'h0;
      ramWe_q     <= 1'b0;
      ramRe_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ramWe_q <= 1'b0;
      ramRe_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            latAddr_q   <= addr[ADDR_W+1:0];
            latFunct3_q <= funct3;
            latWdata_q  <= wdata;
            isStore_q   <= mem_write;
            if (mem_write && (funct3 == F3_W)) begin
              ramWdata_q <= wdata;
              ramWe_q    <= 1'b1;
              state_q    <= WR_ISSUE;
            end else begin
              ramRe_q <= 1'b1;
              state_q <= RD_ISSUE;
            end
          end else if (reject_d) begin
            err_q <= 1'b1;
          end
        end
        RD_ISSUE: begin
          state_q <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          if (isStore_q) begin
            ramWdata_q <= laneStore;
            ramWe_q    <= 1'b1;
            state_q    <= WR_ISSUE;
          end else begin
            rdata_q <= laneLoad;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        WR_ISSUE: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign ram_addr  = latAddr_q[ADDR_W+1:2];
  assign ram_wdata = ramWdata_q;
  assign ram_we    = ramWe_q;
  assign ram_re    = ramRe_q;

  // The RAM port is shared, so a read and a write strobe can never coexist.
  assert property (@(posedge clk) disable iff (!nRst) !(ram_we && ram_re));
  assert property (@(posedge clk) disable iff (!nRst) done |=> !done);
  assert property (@(posedge clk) disable iff (!nRst) err |-> !busy);

endmodule

// File: tb/tb_mem_handler.sv
// Bench for mem_handler: a registered-read word RAM sits behind the DUT, and a
// byte-array memory model predicts every load result, error and latency.
module tb_mem_handler;

  logic        clk;
  logic        nRst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  logic [31:0] ramArr [0:31];
  logic [7:0]  refBytes [0:127];
  int          weCnt;
  int          reCnt;
  int          bothCnt;
  logic [31:0] lastWdata;
  logic [4:0]  lastWaddr;
  int          assertCount;
  int          failCount;

  mem_handler #(.ADDR_W(5)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word RAM with one-cycle registered read; cleared while reset is held.
  always @(posedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < 32; i++) ramArr[i] <= 32'h0;
      ram_rdata <= 32'h0;
    end else begin
      if (ram_we) begin
        ramArr[ram_addr] <= ram_wdata;
        lastWdata        <= ram_wdata;
        lastWaddr        <= ram_addr;
      end
      if (ram_re) ram_rdata <= ramArr[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (ram_we) weCnt <= weCnt + 1;
    if (ram_re) reCnt <= reCnt + 1;
    if (ram_we && ram_re) bothCnt <= bothCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit isLegal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd == wr) return 0;
    if (a > 32'd127) return 0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
    if ((a % accessSize(f3)) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [2:0] f3);
    int          size;
    logic [31:0] v;
    size = accessSize(f3);
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(refBytes[a + i]) << (8 * i));
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return v;
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < accessSize(f3); i++) refBytes[a + i] = 8'(wd >> (8 * i));
  endtask

  // One complete transaction: drive, wait for done/err, then step back to IDLE.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bit          ok;
    int          expLat;
    int          lat;
    int          we0;
    int          re0;
    logic [31:0] expData;
    logic        sawErr;
    logic        sawDone;
    logic        busyAtEnd;
    ok      = isLegal(rd, wr, f3, a);
    expData = rdata;
    if (ok && rd) expData = modelLoad(a, f3);
    if (!ok) expLat = 1;
    else if (rd) expLat = 3;
    else if (f3 == 3'b010) expLat = 2;
    else expLat = 4;

    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    we0       = weCnt;
    re0       = reCnt;
    @(posedge clk);
    lat = 1;
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    while (!done && !err && lat < 12) begin
      @(posedge clk);
      lat++;
      #1;
    end
    sawErr    = err;
    sawDone   = done;
    busyAtEnd = busy;
    if (ok && wr) modelStore(a, f3, wd);
    @(posedge clk);
    #1;

    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " err"}, 32'(sawErr), 32'(!ok));
    checkOutput({tag, " done"}, 32'(sawDone), 32'(ok));
    checkOutput({tag, " busy at end"}, 32'(busyAtEnd), 32'(ok));
    checkOutput({tag, " pulse width"}, 32'({done, err}), 32'h0);
    checkOutput({tag, " writes"}, 32'(weCnt - we0), (ok && wr) ? 32'd1 : 32'd0);
    checkOutput({tag, " reads"}, 32'(reCnt - re0), (ok && !(wr && f3 == 3'b010)) ? 32'd1 : 32'd0);
    checkOutput({tag, " rdata"}, rdata, expData);
  endtask

  initial begin
    int          we0;
    int          re0;
    int          cycles;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;

    assertCount = 0;
    failCount   = 0;
    weCnt       = 0;
    reCnt       = 0;
    bothCnt     = 0;
    lastWdata   = 32'h0;
    lastWaddr   = 5'd0;
    for (int i = 0; i < 128; i++) refBytes[i] = 8'h00;
    nRst      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;

    #1;
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done/err", 32'({done, err}), 32'h0);
    checkOutput("reset strobes", 32'({ram_we, ram_re}), 32'h0);
    checkOutput("reset ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("reset ram_wdata", ram_wdata, 32'h0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;

    $display("[TB] reset during RD_ISSUE of an LB");
    we0 = weCnt;
    @(negedge clk);
    mem_read = 1'b1;
    funct3   = 3'b000;
    addr     = 32'h0F;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    checkOutput("midrst busy before", 32'(busy), 32'h1);
    nRst = 1'b0;
    #1;
    checkOutput("midrst busy", 32'(busy), 32'h0);
    checkOutput("midrst done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    nRst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midrst idle", 32'({busy, done}), 32'h0);
    checkOutput("midrst no write", 32'(weCnt - we0), 32'h0);

    $display("[TB] directed loads and stores");
    applyStimulus("SW pre 0x0C", 1'b0, 1'b1, 3'b010, 32'h0C, 32'h80FF_1234);
    applyStimulus("LB 0x0F", 1'b1, 1'b0, 3'b000, 32'h0F, 32'h0);
    checkOutput("LB 0x0F value", rdata, 32'hFFFF_FF80);
    applyStimulus("LBU 0x0F", 1'b1, 1'b0, 3'b100, 32'h0F, 32'h0);
    checkOutput("LBU 0x0F value", rdata, 32'h0000_0080);
    applyStimulus("LH 0x0E", 1'b1, 1'b0, 3'b001, 32'h0E, 32'h0);
    checkOutput("LH 0x0E value", rdata, 32'hFFFF_80FF);
    applyStimulus("LW 0x0C", 1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
    checkOutput("LW 0x0C value", rdata, 32'h80FF_1234);
    applyStimulus("SB 0x0D", 1'b0, 1'b1, 3'b000, 32'h0D, 32'h0000_00AA);
    checkOutput("SB merged word", lastWdata, 32'h80FF_AA34);
    applyStimulus("LW after SB", 1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
    checkOutput("LW after SB value", rdata, 32'h80FF_AA34);
    applyStimulus("SW 0x7C", 1'b0, 1'b1, 3'b010, 32'h7C, 32'hDEAD_BEEF);
    checkOutput("SW 0x7C ram_addr", 32'(lastWaddr), 32'd31);
    checkOutput("SW 0x7C data", lastWdata, 32'hDEAD_BEEF);

    $display("[TB] rejected requests");
    applyStimulus("LH 0x01", 1'b1, 1'b0, 3'b001, 32'h01, 32'h0);
    applyStimulus("LW 0x82", 1'b1, 1'b0, 3'b010, 32'h82, 32'h0);
    applyStimulus("RD+WR", 1'b1, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
    applyStimulus("SB funct3 100", 1'b0, 1'b1, 3'b100, 32'h10, 32'h55);

    $display("[TB] back-to-back SW then LW with request held during busy");
    we0 = weCnt;
    re0 = reCnt;
    @(negedge clk);
    mem_write = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h40;
    wdata     = 32'h1357_2468;
    cycles    = 0;
    do begin
      @(posedge clk);
      cycles++;
      #1;
    end while (!done && cycles < 12);
    checkOutput("b2b SW latency", 32'(cycles), 32'd2);
    modelStore(32'h40, 3'b010, 32'h1357_2468);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    cycles    = 0;
    do begin
      @(posedge clk);
      cycles++;
      #1;
    end while (!done && cycles < 12);
    mem_read = 1'b0;
    checkOutput("b2b LW cycles", 32'(cycles), 32'd4);
    checkOutput("b2b LW value", rdata, modelLoad(32'h40, 3'b010));
    @(posedge clk);
    #1;
    checkOutput("b2b single write", 32'(weCnt - we0), 32'd1);
    checkOutput("b2b single read", 32'(reCnt - re0), 32'd1);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:             begin rd = 1'b1; wr = 1'b1; end
        1, 2, 3, 4, 5: begin rd = 1'b1; wr = 1'b0; end
        default:       begin rd = 1'b0; wr = 1'b1; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(128, 4095));
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      wd = $urandom;
      applyStimulus($sformatf("rand%0d", n), rd, wr, f3, a, wd);
    end

    checkOutput("never we and re together", 32'(bothCnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_handler.md
Name: mem_handler

Overview:
- Load/store unit between the CPU datapath and the single-port word RAM. It is directly upstream of the RAM.
- Accepts one byte-addressed load or store (byte, half or word) per transaction and translates it into word-granular RAM read/write strobes.
- Sub-word stores use read-modify-write. Loads are extracted and sign- or zero-extended.
- Holds `busy` high so the control unit stalls the PC until `done`.

Parameters:
- ADDR_W, 5: RAM word-address width. RAM depth is 2**ADDR_W words, so the legal byte range is 0 .. 4*2**ADDR_W-1.

Ports:
- clk, in, 1: system clock, rising edge.
- nRst, in, 1: asynchronous active-low reset.
- mem_read, in, 1: load request, sampled in IDLE.
- mem_write, in, 1: store request, sampled in IDLE.
- funct3, in, 3: RV32I width code. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr, in, 32: byte address.
- wdata, in, 32: store data, in the low bits for SB/SH.
- rdata, out, 32: extended load result. Valid while `done` is high; holds otherwise.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at transaction completion.
- err, out, 1: one-cycle pulse for a rejected request.
- ram_addr, out, ADDR_W: word address to the RAM, equal to latched addr[ADDR_W+1:2].
- ram_wdata, out, 32: word to be written.
- ram_we, out, 1: RAM write strobe.
- ram_re, out, 1: RAM read strobe.
- ram_rdata, in, 32: RAM registered read data, valid the cycle after the read address is presented.

Behaviour:
- Reset: state=IDLE; rdata, ram_addr, ram_wdata, and the latched addr/funct3/wdata all 0; done, err, ram_we, ram_re = 0.
  - Reset mid-transaction returns to IDLE immediately.
  - A write whose edge has not yet occurred is never issued.
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, DONE.
- IDLE, on accept edge: latch addr, funct3 and wdata when mem_read^mem_write.
- IDLE rejection: err pulses the next cycle and the state stays IDLE for any of these:
  - mem_read and mem_write both high;
  - misalignment (half with addr[0]=1, word with addr[1:0]!=0);
  - addr[31:ADDR_W+2] != 0;
  - undefined funct3 (including 100/101 on a store).
- Load or SB/SH goes to RD_ISSUE. SW goes to WR_ISSUE with ram_wdata=wdata.
- RD_ISSUE: ram_re=1 with ram_addr stable, then go to RD_CAPTURE.
- RD_CAPTURE: ram_rdata is valid this cycle.
  - Load: select the lane by addr[1:0] (byte) or addr[1] (half), extend per funct3, register into rdata, then go to DONE.
  - SB/SH: merge the wdata low byte/half into the lane and register the result into ram_wdata, then go to WR_ISSUE.
- WR_ISSUE: ram_we=1 for exactly one cycle, ram_re=0, then go to DONE.
- DONE: done=1, then go to IDLE. A new request is sampled the following cycle, never in DONE.
- Latencies, in cycles from accept edge to done high: LW/LB/LH 3; SW 2; SB/SH 4.
- ram_we and ram_re are never both high.
- While `busy`, mem_read and mem_write are ignored.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0.

Decomposition:
- Package mem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state_t enum;
  - a lane-select helper constant.
- Sub-module mem_lane_unit is combinational. It does load extract/extend and store merge from (word, addr[1:0], funct3, wdata).
- The FSM and registers stay in mem_handler.

Test Plan:
- Reset pulled mid-RD_ISSUE of an LB (nRst low for 1 cycle) -> state IDLE, busy=0, done=0, ram_we never asserted.
- Preload word 3 = 0x80FF_1234. LB addr 0x0F -> rdata 0xFFFFFF80, done at cycle 3. LBU addr 0x0F -> 0x00000080. LH addr 0x0E -> 0xFFFF80FF. LW 0x0C -> 0x80FF1234.
- SB wdata 0xAA to addr 0x0D (word 3 = 0x80FF1234) -> ram_we once, ram_wdata 0x80FFAA34, done at cycle 4. Follow-up LW 0x0C returns 0x80FFAA34.
- SW 0xDEADBEEF to addr 0x7C -> ram_addr 31, ram_we 1 cycle, ram_re never high, done at cycle 2.
- Rejections each give err=1 for 1 cycle, busy stays 0, no RAM strobe:
  - LH addr 0x01;
  - LW addr 0x82 (out of range);
  - mem_read and mem_write both high.
- Back-to-back: SW then LW requested with mem_write held during busy -> only one write is issued. LW accepted the cycle after done returns the stored word.
